ptxt_feeder: RTL and testbench

//  Upstream stage of the character cipher core. Buffers a host plaintext message, terminated by NULL (8'h00), in a FIFO.

---
 rtl/cipher_pkg.sv | 25 ++
 rtl/ptxt_fifo.sv | 67 ++++++
 rtl/ptxt_feeder.sv | 198 +++++++++++++++++++
 tb/tb_ptxt_feeder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
// Shared constants and types for the character cipher core and its feeder.
//   P_MOD          modulus of the cipher; valid keys are 0..P_MOD-1
//   NULL_CHAR      message terminator sent by the host
//   MODE_ENC       mode code presented to the core while a char is valid
//   MODE_IDLE      mode code presented while nothing is offered
//   feeder_state_t sequencing states of the plaintext feeder
// ---------------------------------------------------------------------------
package cipher_pkg;

  localparam int         P_MOD     = 227;
  localparam logic [7:0] NULL_CHAR = 8'h00;
  localparam logic [1:0] MODE_ENC  = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/ptxt_fifo.sv
// ---------------------------------------------------------------------------
// ptxt_fifo
// Plaintext buffer between the host and the feeder sequencer, DEPTH x 8.
// Show-ahead read: o_data is always the head entry while not empty.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (empties the FIFO)
//   i_clear  in   synchronous flush
//   i_push   in   write i_data (ignored when full)
//   i_data   in   8-bit char to store
//   i_pop    in   drop head entry (ignored when empty)
//   o_data   out  head entry
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
//   o_count  out  number of entries stored (0..DEPTH)
// ---------------------------------------------------------------------------
module ptxt_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic        w_doPush;
  logic        w_doPop;

  // The extra pointer bit separates "full" from "empty" when the low bits match.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_count  = r_wrPtr - r_rdPtr;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Pointer update; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush && !i_clear) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ptxt_feeder.sv
// ---------------------------------------------------------------------------
// ptxt_feeder
// Upstream stage of the character cipher core. Buffers a NULL-terminated host
// message, then replays it one char at a time to the core with the latched
// key, waiting for a result (or a timeout) before offering the next char.
//   clk, rst      clock (rising edge) / asynchronous active-high reset
//   key_load      latch key_in (only honoured in IDLE)
//   key_in        public key
//   in_valid      host char valid
//   in_ready      feeder accepts a char (FILL and FIFO not full)
//   in_char       host char, 8'h00 terminates the message
//   enc_mode      MODE_ENC while enc_valid, else MODE_IDLE
//   enc_ptxt      char presented to the core (8'h00 otherwise)
//   enc_key       latched key
//   enc_valid     char presented this cycle
//   enc_c_ready   core result ready
//   enc_err       core rejected the char
//   busy          sequencer not idle
//   msg_done      one-cycle pulse when the message is finished
//   char_count    chars issued in the current/last message
//   err_char      one-cycle pulse when the core flags enc_err
//   err_timeout   one-cycle pulse when the core does not answer in TIMEOUT cycles
//   err_key       sticky flag: latched key >= P_MOD
// ---------------------------------------------------------------------------
module ptxt_feeder
  import cipher_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4,
  parameter int P_MOD   = cipher_pkg::P_MOD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_load,
  input  logic [7:0]                   key_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_char,
  output logic [1:0]                   enc_mode,
  output logic [7:0]                   enc_ptxt,
  output logic [7:0]                   enc_key,
  output logic                         enc_valid,
  input  logic                         enc_c_ready,
  input  logic                         enc_err,
  output logic                         busy,
  output logic                         msg_done,
  output logic [$clog2(DEPTH+1)-1:0]   char_count,
  output logic                         err_char,
  output logic                         err_timeout,
  output logic                         err_key
);

  localparam int                 AW       = $clog2(DEPTH);
  localparam int                 TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT);
  localparam logic [7:0]         KEY_LIM  = 8'(P_MOD);
  localparam logic [AW:0]        LAST_FREE = (AW+1)'(DEPTH - 1);

  feeder_state_t                 r_state;
  feeder_state_t                 w_nextState;
  logic [7:0]                    r_key;
  logic                          r_errKey;
  logic [$clog2(DEPTH+1)-1:0]    r_charCount;
  logic [TW-1:0]                 r_waitCnt;

  logic                          w_push;
  logic                          w_pop;
  logic                          w_clear;
  logic                          w_resolved;
  logic [7:0]                    w_head;
  logic                          w_full;
  logic                          w_empty;
  logic [AW:0]                   w_count;

  ptxt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (in_char),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign enc_key    = r_key;
  assign err_key    = r_errKey;
  assign char_count = r_charCount;
  assign busy       = (r_state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next state and all per-cycle outputs. The core-facing outputs decode
  // straight from the state so an asynchronous reset drops enc_valid at once.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    w_resolved  = 1'b0;
    in_ready    = 1'b0;
    enc_valid   = 1'b0;
    enc_ptxt    = NULL_CHAR;
    enc_mode    = MODE_IDLE;
    msg_done    = 1'b0;
    err_char    = 1'b0;
    err_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_nextState = ST_FILL;
      end
      ST_FILL: begin
        in_ready = !w_full;
        if (in_valid && !w_full) begin
          if (in_char == NULL_CHAR) begin
            w_nextState = w_empty ? ST_DONE : ST_ISSUE;
          end else begin
            w_push = 1'b1;
            // The char that fills the last slot ends the message implicitly.
            if (w_count == LAST_FREE) w_nextState = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (r_errKey) begin
          w_clear     = 1'b1;
          w_nextState = ST_DONE;
        end else begin
          w_pop       = 1'b1;
          enc_valid   = 1'b1;
          enc_ptxt    = w_head;
          enc_mode    = MODE_ENC;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Core error outranks a simultaneous ready; timeout only if neither.
        if (enc_err) begin
          err_char   = 1'b1;
          w_resolved = 1'b1;
        end else if (enc_c_ready) begin
          w_resolved = 1'b1;
        end else if (r_waitCnt == TMO_LAST) begin
          err_timeout = 1'b1;
          w_resolved  = 1'b1;
        end
        if (w_resolved) w_nextState = w_empty ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        msg_done    = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Key latch and range check; only IDLE may change the key so it stays
  // stable across a whole message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key    <= 8'h00;
      r_errKey <= 1'b0;
    end else if (r_state == ST_IDLE && key_load) begin
      r_key    <= key_in;
      r_errKey <= (key_in >= KEY_LIM);
    end
  end

  // Char counter: cleared when a new message starts filling, bumped per issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_charCount <= '0;
    end else if (r_state == ST_IDLE && w_nextState == ST_FILL) begin
      r_charCount <= '0;
    end else if (enc_valid) begin
      r_charCount <= r_charCount + 1'b1;
    end
  end

  // Wait counter: the first WAIT cycle reads 1, so TIMEOUT is hit on the
  // TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_waitCnt <= TW'(1);
    end else if (r_state == ST_WAIT && !w_resolved) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ptxt_feeder.sv
// ---------------------------------------------------------------------------
// tb_ptxt_feeder
// Directed bench for ptxt_feeder with a registered core stub that answers one
// cycle after enc_valid: normally with enc_c_ready, with enc_err for the char
// equal to stubErrChar, and not at all for the char equal to stubSilentChar.
// ---------------------------------------------------------------------------
module tb_ptxt_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_load = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic [1:0] enc_mode;
  logic [7:0] enc_ptxt;
  logic [7:0] enc_key;
  logic       enc_valid;
  logic       enc_c_ready = 1'b0;
  logic       enc_err = 1'b0;
  logic       busy;
  logic       msg_done;
  logic [4:0] char_count;
  logic       err_char;
  logic       err_timeout;
  logic       err_key;

  int total = 0;
  int bad   = 0;

  logic [7:0] stubErrChar    = 8'hFF;
  logic [7:0] stubSilentChar = 8'hFF;

  int         cyc = 0;
  logic [7:0] issued[$];
  int         issueCyc[$];
  int         msgDoneCnt;
  int         errCharCnt;
  int         errTimeoutCnt;
  int         timeoutCyc;
  int         modeBad;
  int         idleBad;
  logic [7:0] expKey;

  ptxt_feeder #(.DEPTH(16), .TIMEOUT(4), .P_MOD(227)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_load    (key_load),
    .key_in      (key_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .enc_mode    (enc_mode),
    .enc_ptxt    (enc_ptxt),
    .enc_key     (enc_key),
    .enc_valid   (enc_valid),
    .enc_c_ready (enc_c_ready),
    .enc_err     (enc_err),
    .busy        (busy),
    .msg_done    (msg_done),
    .char_count  (char_count),
    .err_char    (err_char),
    .err_timeout (err_timeout),
    .err_key     (err_key)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered core stub: its answer appears in the cycle after enc_valid.
  always @(posedge clk) begin
    enc_c_ready <= 1'b0;
    enc_err     <= 1'b0;
    if (enc_valid && !rst) begin
      if (enc_ptxt == stubErrChar) begin
        enc_err     <= 1'b1;
        enc_c_ready <= 1'b1;
      end else if (enc_ptxt != stubSilentChar) begin
        enc_c_ready <= 1'b1;
      end
    end
  end

  // Mid-cycle monitor recording what the core sees and the event pulses.
  always @(negedge clk) begin
    if (enc_valid) begin
      issued.push_back(enc_ptxt);
      issueCyc.push_back(cyc);
      if (enc_mode !== 2'b10 || enc_key !== expKey) modeBad++;
    end else if (enc_ptxt !== 8'h00 || enc_mode !== 2'b00) begin
      idleBad++;
    end
    if (msg_done)    msgDoneCnt++;
    if (err_char)    errCharCnt++;
    if (err_timeout) begin
      errTimeoutCnt++;
      timeoutCyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearMon();
    @(negedge clk);
    #1;
    issued.delete();
    issueCyc.delete();
    msgDoneCnt    = 0;
    errCharCnt    = 0;
    errTimeoutCnt = 0;
    timeoutCyc    = -1;
    modeBad       = 0;
    idleBad       = 0;
  endtask

  task automatic loadKey(input logic [7:0] k);
    @(negedge clk);
    key_load = 1'b1;
    key_in   = k;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Offer one host char and hold it until the feeder takes it.
  task automatic applyStimulus(input logic [7:0] ch);
    bit got;
    got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = ch;
    for (int i = 0; i < 50 && !got; i++) begin
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    if (!got) checkOutput("host_accept_timeout", 0, 1);
  endtask

  task automatic sendMsg(input string s, input bit withTerm);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    if (withTerm) applyStimulus(8'h00);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    expKey = 8'h00;
    clearMon();

    // Reset values while rst is held.
    #1;
    checkOutput("rst_enc_valid", enc_valid, 0);
    checkOutput("rst_enc_ptxt", enc_ptxt, 8'h00);
    checkOutput("rst_enc_mode", enc_mode, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_char_count", char_count, 0);
    checkOutput("rst_err_key", err_key, 0);
    checkOutput("rst_enc_key", enc_key, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: key 3, "abc" with prompt acks.
    $display("[TB] test 1: basic message");
    expKey = 8'd3;
    loadKey(8'd3);
    checkOutput("t1_enc_key", enc_key, 3);
    clearMon();
    sendMsg("abc", 1'b1);
    waitIdle();
    checkOutput("t1_issued", issued.size(), 3);
    if (issued.size() == 3) begin
      checkOutput("t1_char0", issued[0], 8'h61);
      checkOutput("t1_char1", issued[1], 8'h62);
      checkOutput("t1_char2", issued[2], 8'h63);
      checkOutput("t1_spacing", issueCyc[1] - issueCyc[0], 2);
    end
    checkOutput("t1_char_count", char_count, 3);
    checkOutput("t1_msg_done", msgDoneCnt, 1);
    checkOutput("t1_mode_key", modeBad, 0);
    checkOutput("t1_idle_outputs", idleBad, 0);

    // 2: out-of-range key blocks issuing; a valid reload clears the flag.
    $display("[TB] test 2: bad key");
    loadKey(8'd230);
    checkOutput("t2_err_key_set", err_key, 1);
    clearMon();
    sendMsg("a", 1'b1);
    waitIdle();
    checkOutput("t2_no_issue", issued.size(), 0);
    checkOutput("t2_msg_done", msgDoneCnt, 1);
    checkOutput("t2_char_count", char_count, 0);
    checkOutput("t2_err_key_sticky", err_key, 1);
    expKey = 8'd5;
    loadKey(8'd5);
    checkOutput("t2_err_key_clr", err_key, 0);

    // 3: core rejects the middle char; message still completes.
    $display("[TB] test 3: char error");
    stubErrChar = 8'h62;
    clearMon();
    sendMsg("abc", 1'b1);
    waitIdle();
    stubErrChar = 8'hFF;
    checkOutput("t3_err_char", errCharCnt, 1);
    checkOutput("t3_issued", issued.size(), 3);
    if (issued.size() == 3) checkOutput("t3_char2", issued[2], 8'h63);
    checkOutput("t3_char_count", char_count, 3);
    checkOutput("t3_no_timeout", errTimeoutCnt, 0);

    // 4: core silent on the first char.
    $display("[TB] test 4: timeout");
    stubSilentChar = 8'h64;
    clearMon();
    sendMsg("de", 1'b1);
    waitIdle();
    stubSilentChar = 8'hFF;
    checkOutput("t4_err_timeout", errTimeoutCnt, 1);
    checkOutput("t4_issued", issued.size(), 2);
    if (issued.size() == 2) begin
      checkOutput("t4_timeout_lat", timeoutCyc - issueCyc[0], 4);
      checkOutput("t4_next_issue", issueCyc[1] - timeoutCyc, 1);
      checkOutput("t4_char1", issued[1], 8'h65);
    end
    checkOutput("t4_msg_done", msgDoneCnt, 1);

    // 5: sixteen chars fill the FIFO and end the message.
    $display("[TB] test 5: full FIFO");
    clearMon();
    sendMsg("ABCDEFGHIJKLMNOP", 1'b0);
    checkOutput("t5_in_ready_low", in_ready, 0);
    waitIdle();
    checkOutput("t5_issued", issued.size(), 16);
    if (issued.size() == 16) checkOutput("t5_last", issued[15], 8'h50);
    checkOutput("t5_char_count", char_count, 16);
    checkOutput("t5_msg_done", msgDoneCnt, 1);

    // 6: reset during WAIT of the second char.
    $display("[TB] test 6: reset mid-message");
    clearMon();
    sendMsg("wxy", 1'b1);
    begin
      int n;
      n = 0;
      while (!(enc_valid && enc_ptxt == 8'h78) && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("t6_reached_char2", enc_valid && enc_ptxt == 8'h78, 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_enc_valid", enc_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_char_count", char_count, 0);
    checkOutput("t6_enc_key", enc_key, 0);
    checkOutput("t6_enc_ptxt", enc_ptxt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_no_msg_done", msgDoneCnt, 0);
    expKey = 8'd7;
    loadKey(8'd7);
    clearMon();
    sendMsg("z", 1'b1);
    waitIdle();
    checkOutput("t6_issued", issued.size(), 1);
    if (issued.size() == 1) checkOutput("t6_char", issued[0], 8'h7A);
    checkOutput("t6_new_count", char_count, 1);
    checkOutput("t6_new_done", msgDoneCnt, 1);
    checkOutput("t6_mode_key", modeBad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
